// File: rtl/clk_en_frac_gen_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : clk_en_frac_gen_pkg
// Description : Shared constants, channel indices and increment helper for
//               the fractional clock-enable generator.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_en_frac_gen_pkg;

    // Accumulator width used by the system-level instance.
    localparam int CLK_EN_ACC_WIDTH = 24;

    // Number of enable channels in the system-level instance.
    localparam int NUM_CLK_EN_CH    = 3;

    // System clock frequency (OPL3 master clock) used to derive increments.
    localparam real CLK_FREQ        = 14_318_180.0;

    // Channel assignment within the system-level instance.
    typedef enum logic [1:0] {
        CLK_EN_SAMPLE = 2'd0,
        CLK_EN_TIMER1 = 2'd1,
        CLK_EN_TIMER2 = 2'd2
    } clk_en_ch_t;

    // Increment that yields an average enable rate of f_out:
    // round(f_out / CLK_FREQ * 2^CLK_EN_ACC_WIDTH). Intended for elaboration
    // time constant evaluation only.
    function automatic logic [CLK_EN_ACC_WIDTH-1:0] calc_clk_en_incr(input real f_out);
        real w_scaled;
        w_scaled = f_out / CLK_FREQ * (2.0 ** CLK_EN_ACC_WIDTH);
        return CLK_EN_ACC_WIDTH'($rtoi(w_scaled + 0.5));
    endfunction

    // Sample clock enable (~49.7 kHz output sample rate).
    localparam logic [CLK_EN_ACC_WIDTH-1:0] SAMPLE_INCR = calc_clk_en_incr(49_716.0);
    // Timer 1 tick: one every 80 us.
    localparam logic [CLK_EN_ACC_WIDTH-1:0] TIMER1_INCR = calc_clk_en_incr(12_500.0);
    // Timer 2 tick: one every 320 us.
    localparam logic [CLK_EN_ACC_WIDTH-1:0] TIMER2_INCR = calc_clk_en_incr(3_125.0);

endpackage
`default_nettype wire

// File: rtl/clk_en_frac_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : clk_en_frac_gen_if
// Description : Control/status bundle of the fractional clock-enable
//               generator. The master side owns rate control, the slave
//               side (the generator) returns pulses and pending flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_en_frac_gen_if #(
    parameter int NUM_CH    = 3,
    parameter int ACC_WIDTH = 24
);
    // Per-channel run enable.
    logic [NUM_CH-1:0]           ch_enable;
    // Packed increments; channel n occupies [n*ACC_WIDTH +: ACC_WIDTH].
    logic [NUM_CH*ACC_WIDTH-1:0] ch_incr;
    // One-cycle strobes capturing the matching ch_incr slice.
    logic [NUM_CH-1:0]           incr_load;
    // Clears every accumulator so all channels restart in phase.
    logic                        sync_restart;
    // Registered one-cycle enable pulses.
    logic [NUM_CH-1:0]           clk_en;
    // A captured increment is waiting for its pulse boundary.
    logic [NUM_CH-1:0]           incr_pending;

    modport master (
        output ch_enable,
        output ch_incr,
        output incr_load,
        output sync_restart,
        input  clk_en,
        input  incr_pending
    );

    modport slave (
        input  ch_enable,
        input  ch_incr,
        input  incr_load,
        input  sync_restart,
        output clk_en,
        output incr_pending
    );

endinterface
`default_nettype wire

// File: rtl/clk_en_frac_gen_ch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : clk_en_frac_gen_ch
// Description : One phase-accumulator channel. Every running cycle adds the
//               active increment to the accumulator; the carry out of the
//               sum becomes a one-cycle enable pulse. A shadow increment lets
//               software retune the rate without glitches: it only becomes
//               active on a pulse boundary (or whenever the channel is idle).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_frac_gen_ch #(
    parameter int                   ACC_WIDTH    = 24,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INCR = '0
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  i_enable,
    input  wire  [ACC_WIDTH-1:0] i_incr,
    input  wire                  i_load,
    input  wire                  i_restart,
    output logic                 o_clk_en,
    output logic                 o_pending
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_active;
    logic [ACC_WIDTH-1:0] r_shadow;
    logic                 r_clk_en;
    logic                 r_pending;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic                 w_hold;
    logic                 w_apply;

    // Accumulator sum with carry, and the decision whether a pending shadow
    // may take over this edge (idle channel or pulse boundary).
    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_active};
        w_carry = w_sum[ACC_WIDTH];
        w_hold  = i_restart || !i_enable;
        w_apply = r_pending && (w_hold || w_carry);
    end

    // Accumulator, pulse, active/shadow increments and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_active  <= DEFAULT_INCR;
            r_shadow  <= DEFAULT_INCR;
            r_clk_en  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            // Restart and disable both park the phase at zero so the next
            // running edge starts a fresh period. The carry computed from
            // the old phase is discarded in that case.
            r_acc    <= w_hold ? '0 : w_sum[ACC_WIDTH-1:0];
            r_clk_en <= !w_hold && w_carry;

            // An idle channel has no pulse boundary to wait for, so a load
            // goes straight to the active increment. Otherwise the old
            // shadow is promoted only when allowed; this edge's sum already
            // used the previous active value.
            if (i_load && !i_enable) begin
                r_active <= i_incr;
            end else if (w_apply) begin
                r_active <= r_shadow;
            end

            if (i_load) begin
                r_shadow <= i_incr;
            end

            // A new load always wins over the promotion of an older one:
            // the freshly captured value stays pending.
            if (i_load) begin
                r_pending <= i_enable;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_en_frac_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : clk_en_frac_gen
// Description : Multi-channel fractional clock-enable generator. Each channel
//               is an independent phase accumulator whose average pulse rate
//               is CLK_FREQ*incr/2^ACC_WIDTH, exact over time. A common
//               restart realigns the phase of every channel.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_frac_gen
    import clk_en_frac_gen_pkg::*;
#(
    parameter int                   NUM_CH       = NUM_CLK_EN_CH,
    parameter int                   ACC_WIDTH    = CLK_EN_ACC_WIDTH,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INCR = '0
) (
    input  wire               clk,
    input  wire               reset,
    clk_en_frac_gen_if.slave  bus
);

    logic [NUM_CH-1:0] w_clk_en;
    logic [NUM_CH-1:0] w_pending;

    // One accumulator channel per enable output; only the restart strobe is
    // shared between them.
    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            clk_en_frac_gen_ch #(
                .ACC_WIDTH    (ACC_WIDTH),
                .DEFAULT_INCR (DEFAULT_INCR)
            ) u_ch (
                .clk       (clk),
                .rst       (reset),
                .i_enable  (bus.ch_enable[n]),
                .i_incr    (bus.ch_incr[n*ACC_WIDTH +: ACC_WIDTH]),
                .i_load    (bus.incr_load[n]),
                .i_restart (bus.sync_restart),
                .o_clk_en  (w_clk_en[n]),
                .o_pending (w_pending[n])
            );
        end
    endgenerate

    assign bus.clk_en       = w_clk_en;
    assign bus.incr_pending = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_frac_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clk_en_frac_gen
// Description : Self-checking bench for clk_en_frac_gen (3 channels, 8-bit
//               accumulators). Directed scenarios plus a randomized run
//               checked against a behavioural phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_en_frac_gen;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int MOD = 256;
    localparam int IW  = NCH * W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    clk_en_frac_gen_if #(.NUM_CH(NCH), .ACC_WIDTH(W)) bus ();

    clk_en_frac_gen #(
        .NUM_CH       (NCH),
        .ACC_WIDTH    (W),
        .DEFAULT_INCR ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase in [0,MOD), rate, queued rate, pulse output.
    int m_phase [NCH];
    int m_rate  [NCH];
    int m_next  [NCH];
    bit m_pend  [NCH];
    bit m_pulse [NCH];

    // Apply one clock edge worth of rules to the model using current inputs.
    function automatic void model_edge();
        for (int c = 0; c < NCH; c++) begin
            int  total_phase;
            bit  running;
            bit  wrapped;
            int  v;
            v = int'(bus.ch_incr[c*W +: W]);
            if (reset) begin
                m_phase[c] = 0;
                m_rate[c]  = 0;
                m_next[c]  = 0;
                m_pend[c]  = 0;
                m_pulse[c] = 0;
            end else begin
                running     = bus.ch_enable[c] && !bus.sync_restart;
                total_phase = m_phase[c] + m_rate[c];
                wrapped     = (total_phase >= MOD);
                m_pulse[c]  = running && wrapped;
                if (m_pend[c] && (!running || wrapped)) begin
                    m_rate[c] = m_next[c];
                    m_pend[c] = 0;
                end
                m_phase[c] = running ? (total_phase % MOD) : 0;
                if (bus.incr_load[c]) begin
                    m_next[c] = v;
                    if (bus.ch_enable[c]) begin
                        m_pend[c] = 1;
                    end else begin
                        m_rate[c] = v;
                        m_pend[c] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ch_enable    = '0;
        bus.ch_incr      = '0;
        bus.incr_load    = '0;
        bus.sync_restart = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_ch(input int c, input int v);
        bus.ch_incr[c*W +: W] = W'(v);
        bus.incr_load[c]      = 1'b1;
        step();
        bus.incr_load[c]      = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        total++;
        if (bus.clk_en !== 3'b000) begin
            bad++;
            $display("FAIL reset_clk_en: got %b want 000", bus.clk_en);
        end
        total++;
        if (bus.incr_pending !== 3'b000) begin
            bad++;
            $display("FAIL reset_pending: got %b want 000", bus.incr_pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_no_load();
        int pulses;
        int pends;
        pulses = 0;
        pends  = 0;
        bus.ch_enable = 3'b111;
        for (int e = 1; e <= 1000; e++) begin
            step();
            if (bus.clk_en !== 3'b000) pulses++;
            if (bus.incr_pending !== 3'b000) pends++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL no_load_pulses: got %0d cycles with pulses want 0", pulses);
        end
        total++;
        if (pends !== 0) begin
            bad++;
            $display("FAIL no_load_pending: got %0d cycles pending want 0", pends);
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_rate64();
        int cnt;
        int first;
        int offgrid;
        cnt = 0; first = -1; offgrid = 0;
        do_reset();
        load_ch(0, 64);
        total++;
        if (bus.incr_pending[0] !== 1'b0) begin
            bad++;
            $display("FAIL rate64_load_pending: got %b want 0", bus.incr_pending[0]);
        end
        bus.ch_enable[0] = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            step();
            if (bus.clk_en[0] === 1'b1) begin
                cnt++;
                if (first < 0) first = e;
                if ((e % 4) != 0) offgrid++;
            end
        end
        total++;
        if (first !== 4) begin
            bad++;
            $display("FAIL rate64_first: got edge %0d want 4", first);
        end
        total++;
        if (cnt !== 250) begin
            bad++;
            $display("FAIL rate64_count: got %0d want 250", cnt);
        end
        total++;
        if (offgrid !== 0) begin
            bad++;
            $display("FAIL rate64_grid: got %0d off-grid pulses want 0", offgrid);
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_rate96();
        int cnt;
        bit exp;
        cnt = 0;
        do_reset();
        load_ch(1, 96);
        bus.ch_enable[1] = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            step();
            exp = ((e * 96) / MOD) != (((e - 1) * 96) / MOD);
            if (bus.clk_en[1] === 1'b1) cnt++;
            if (e <= 16) begin
                total++;
                if (bus.clk_en[1] !== exp) begin
                    bad++;
                    $display("FAIL rate96_edge%0d: got %b want %b", e, bus.clk_en[1], exp);
                end
            end
        end
        total++;
        if (cnt !== 375) begin
            bad++;
            $display("FAIL rate96_count: got %0d want 375", cnt);
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_rate_change();
        bit found;
        bit exp_en [7];
        bit exp_pd [7];
        exp_en = '{0, 0, 0, 1, 0, 1, 0};
        exp_pd = '{0, 1, 1, 0, 0, 0, 0};
        found = 0;
        do_reset();
        load_ch(0, 64);
        bus.ch_enable[0] = 1'b1;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (bus.clk_en[0] === 1'b1) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rate_change_wait: got no pulse in 16 cycles want a pulse");
        end
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                bus.ch_incr[0 +: W] = 8'd128;
                bus.incr_load[0]    = 1'b1;
            end
            step();
            bus.incr_load[0] = 1'b0;
            total++;
            if (bus.clk_en[0] !== exp_en[k] || bus.incr_pending[0] !== exp_pd[k]) begin
                bad++;
                $display("FAIL rate_change_p%0d: got en=%b pend=%b want en=%b pend=%b",
                         k + 1, bus.clk_en[0], bus.incr_pending[0], exp_en[k], exp_pd[k]);
            end
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_restart();
        logic [2:0] exp [6];
        exp = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b010};
        do_reset();
        load_ch(0, 64);
        load_ch(1, 96);
        bus.ch_enable = 3'b011;
        for (int e = 1; e <= 5; e++) step();
        bus.sync_restart = 1'b1;
        step();
        bus.sync_restart = 1'b0;
        total++;
        if (bus.clk_en !== 3'b000) begin
            bad++;
            $display("FAIL restart_edge: got %b want 000", bus.clk_en);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (bus.clk_en !== exp[k]) begin
                bad++;
                $display("FAIL restart_after%0d: got %b want %b", k + 1, bus.clk_en, exp[k]);
            end
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_reset_midrun();
        int pulses;
        pulses = 0;
        do_reset();
        load_ch(0, 64);
        bus.ch_enable[0] = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        bus.ch_incr[0 +: W] = 8'd128;
        bus.incr_load[0]    = 1'b1;
        step();
        bus.incr_load[0] = 1'b0;
        total++;
        if (bus.incr_pending[0] !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pending_before: got %b want 1", bus.incr_pending[0]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (bus.clk_en !== 3'b000 || bus.incr_pending !== 3'b000) begin
            bad++;
            $display("FAIL midrun_reset: got en=%b pend=%b want 000/000", bus.clk_en, bus.incr_pending);
        end
        bus.ch_enable = 3'b111;
        for (int e = 1; e <= 300; e++) begin
            step();
            if (bus.clk_en !== 3'b000 || bus.incr_pending !== 3'b000) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL midrun_idle: got %0d active cycles want 0", pulses);
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_disabled_load();
        do_reset();
        load_ch(2, 32);
        total++;
        if (bus.incr_pending[2] !== 1'b0) begin
            bad++;
            $display("FAIL disabled_load_pending: got %b want 0", bus.incr_pending[2]);
        end
        bus.ch_enable[2] = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            total++;
            if (bus.clk_en[2] !== ((e % 8) == 0)) begin
                bad++;
                $display("FAIL disabled_load_edge%0d: got %b want %b", e, bus.clk_en[2], (e % 8) == 0);
            end
        end
        bus.ch_enable = '0;
    endtask

    task automatic test_random();
        logic [NCH-1:0] exp_en;
        logic [NCH-1:0] exp_pd;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                bus.ch_enable[c] = ($urandom_range(0, 7) != 0);
                bus.incr_load[c] = ($urandom_range(0, 15) == 0);
            end
            bus.ch_incr      = IW'($urandom());
            bus.sync_restart = ($urandom_range(0, 63) == 0);
            reset            = ($urandom_range(0, 499) == 0);
            step();
            for (int c = 0; c < NCH; c++) begin
                exp_en[c] = m_pulse[c];
                exp_pd[c] = m_pend[c];
            end
            total++;
            if (bus.clk_en !== exp_en || bus.incr_pending !== exp_pd) begin
                bad++;
                $display("FAIL random_cycle%0d: got en=%b pend=%b want en=%b pend=%b",
                         i, bus.clk_en, bus.incr_pending, exp_en, exp_pd);
            end
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_no_load();
        test_rate64();
        test_rate96();
        test_rate_change();
        test_restart();
        test_reset_midrun();
        test_disabled_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
